// File: rtl/rv_pkg.sv
// Shared encodings and the MEM/WB payload record. Payload fields are sized for the
// widest legal configuration (XLEN=64, REG_AW<=8); narrower stages zero-extend into them.
package rv_pkg;

    localparam int MAX_XLEN   = 64;
    localparam int MAX_REG_AW = 8;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic [MAX_XLEN-1:0]   alu_res;
        logic [MAX_XLEN-1:0]   mem_word;
        logic [MAX_XLEN-1:0]   pc4;
        logic [MAX_REG_AW-1:0] rd;
        logic [1:0]            wb_sel;
        logic [2:0]            funct3;
        logic                  reg_write;
    } mem_wb_payload_t;

endpackage

// File: rtl/load_extend.sv
// Load byte/half/word selection and sign/zero extension; purely combinational.
// Misalignment is not detected: the half offset is forced even, the word offset to a word boundary.
module load_extend
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                  i_funct3,
    input  logic [$clog2(XLEN/8)-1:0]   i_off,
    input  logic [XLEN-1:0]             i_word,
    output logic [XLEN-1:0]             o_data
);

    localparam int OFFW = $clog2(XLEN/8);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_word;

    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_word[{i_off[OFFW-1:1], 4'b0000} +: 16];

    generate
        if (XLEN == 64) begin : g_word64
            assign w_word = i_off[OFFW-1] ? i_word[XLEN-1:32] : i_word[31:0];
        end else begin : g_word32
            assign w_word = i_word[31:0];
        end
    endgenerate

    // LW at XLEN=32 reduces to a passthrough because the word is the whole register.
    always_comb begin
        o_data = i_word;
        case (i_funct3)
            F3_LB:   o_data = XLEN'($signed(w_byte));
            F3_LH:   o_data = XLEN'($signed(w_half));
            F3_LW:   o_data = XLEN'($signed(w_word));
            F3_LBU:  o_data = XLEN'(w_byte);
            F3_LHU:  o_data = XLEN'(w_half);
            F3_LWU:  o_data = XLEN'(w_word);
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM/WB stage: 2-entry skid buffer (main + skid), 1-cycle accept-to-valid, in_ready registered
// (drops only when skid holds an entry); synchronous flush; writeback mux and forwarding port.
module mem_wb_pipe_stage
    import rv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   alu_res_in,
    input  logic [XLEN-1:0]   mem_word_in,
    input  logic [XLEN-1:0]   pc4_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [1:0]        wb_sel_in,
    input  logic [2:0]        funct3_in,
    input  logic              reg_write_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data
);

    localparam int OFFW = $clog2(XLEN/8);

    logic            r_main_vld;
    logic            r_skid_vld;
    mem_wb_payload_t r_main;
    mem_wb_payload_t r_skid;
    mem_wb_payload_t w_in;
    logic            w_accept;
    logic            w_retire;
    logic            w_wr;
    logic [XLEN-1:0] w_ext;
    logic            w_unused_hi;

    always_comb begin
        w_in           = '0;
        w_in.alu_res   = MAX_XLEN'(alu_res_in);
        w_in.mem_word  = MAX_XLEN'(mem_word_in);
        w_in.pc4       = MAX_XLEN'(pc4_in);
        w_in.rd        = MAX_REG_AW'(rd_in);
        w_in.wb_sel    = wb_sel_in;
        w_in.funct3    = funct3_in;
        w_in.reg_write = reg_write_in;
    end

    assign w_accept = in_valid & ~r_skid_vld;
    assign w_retire = r_main_vld & out_ready;

    // Skid only fills while main is stalled, so main is never empty while skid is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_retire && r_skid_vld) begin
            r_main     <= r_skid;
            r_skid_vld <= 1'b0;
        end else if (w_accept && (!r_main_vld || w_retire)) begin
            r_main     <= w_in;
            r_main_vld <= 1'b1;
        end else if (w_accept) begin
            r_skid     <= w_in;
            r_skid_vld <= 1'b1;
        end else if (w_retire) begin
            r_main_vld <= 1'b0;
        end
    end

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .i_funct3 (r_main.funct3),
        .i_off    (r_main.alu_res[OFFW-1:0]),
        .i_word   (r_main.mem_word[XLEN-1:0]),
        .o_data   (w_ext)
    );

    always_comb begin
        case (r_main.wb_sel)
            WB_MEM:  wb_data = w_ext;
            WB_PC4:  wb_data = r_main.pc4[XLEN-1:0];
            default: wb_data = r_main.alu_res[XLEN-1:0];
        endcase
    end

    assign w_wr      = r_main_vld & r_main.reg_write & (r_main.rd != '0);
    assign in_ready  = ~r_skid_vld;
    assign out_valid = r_main_vld;
    assign wb_rd     = r_main.rd[REG_AW-1:0];
    assign wb_we     = w_wr & out_ready;
    assign fwd_valid = (FWD_EN != 0) & w_wr;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = wb_data;

    // Upper payload bits are only live in the widest configuration.
    assign w_unused_hi = ^{r_main.alu_res, r_main.mem_word, r_main.pc4, r_main.rd};

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Randomized + directed bench for mem_wb_pipe_stage with a queue scoreboard and an
// independent monitor; expected writeback values come from a plain-arithmetic model.
module tb_mem_wb_pipe_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   alu_res_in;
    logic [XLEN-1:0]   mem_word_in;
    logic [XLEN-1:0]   pc4_in;
    logic [REG_AW-1:0] rd_in;
    logic [1:0]        wb_sel_in;
    logic [2:0]        funct3_in;
    logic              reg_write_in;
    logic              out_valid;
    logic              out_ready;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_data;

    always #5 clk = ~clk;

    mem_wb_pipe_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_res_in   (alu_res_in),
        .mem_word_in  (mem_word_in),
        .pc4_in       (pc4_in),
        .rd_in        (rd_in),
        .wb_sel_in    (wb_sel_in),
        .funct3_in    (funct3_in),
        .reg_write_in (reg_write_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference writeback value for XLEN=32, straight from the load rules.
    function automatic logic [31:0] ref_wb(input logic [31:0] alu, input logic [31:0] mem,
                                           input logic [31:0] pc4, input logic [1:0] sel,
                                           input logic [2:0] f3);
        int unsigned off;
        logic [31:0] b;
        logic [31:0] h;
        off = int'(alu[1:0]);
        b   = (mem >> (8 * off)) & 32'hFF;
        h   = (mem >> (8 * ((off / 2) * 2))) & 32'hFFFF;
        if (sel == 2'd2) return pc4;
        if (sel != 2'd1) return alu;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return mem;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: out_valid=1 rd=%0d data=0x%0h, expected no entry", wb_rd, wb_data);
                end else begin
                    chk("wb_rd", 64'(wb_rd), 64'(q[0].rd));
                    chk("wb_data", 64'(wb_data), 64'(q[0].data));
                    chk("wb_we", 64'(wb_we), 64'(q[0].wr & out_ready));
                    chk("fwd_valid", 64'(fwd_valid), 64'(q[0].wr));
                    chk("fwd_rd", 64'(fwd_rd), 64'(q[0].rd));
                    chk("fwd_data", 64'(fwd_data), 64'(q[0].data));
                    if (out_ready) void'(q.pop_front());
                end
            end else begin
                chk("idle_we_fwd", 64'({wb_we, fwd_valid}), 64'd0);
            end
        end
    end

    // One cycle of stimulus; called #1 after a rising edge.
    task automatic step(input logic iv, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc4, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [2:0] f3, input logic rw, input logic ordy, input logic fl,
                        input logic ovr, input logic [31:0] ovr_data);
        logic acc;
        exp_t e;
        acc    = iv && (q.size() < 2) && !fl;
        e.rd   = rd;
        e.data = ovr ? ovr_data : ref_wb(alu, mem, pc4, sel, f3);
        e.wr   = rw && (rd != 5'd0);
        in_valid     = iv;
        alu_res_in   = alu;
        mem_word_in  = mem;
        pc4_in       = pc4;
        rd_in        = rd;
        wb_sel_in    = sel;
        funct3_in    = f3;
        reg_write_in = rw;
        out_ready    = ordy & ~fl;
        flush        = fl;
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else if (acc) q.push_back(e);
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 2'd0, 3'd0, 1'b0, ordy, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic send(input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [2:0] f3, input logic ordy);
        step(1'b1, alu, mem, alu + 32'd4, rd, sel, f3, 1'b1, ordy, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_res_in = '0; mem_word_in = '0; pc4_in = '0; rd_in = '0;
        wb_sel_in = '0; funct3_in = '0; reg_write_in = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_wb_we", 64'(wb_we), 64'd0);
        chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back stream with the sink always ready.
        for (int i = 1; i <= 5; i++)
            send(32'h100 * i, $urandom, 5'(i), 2'd0, 3'd0, 1'b1);
        idle(1'b1);

        // Stall: A to main, B to skid, C refused, then drain in order.
        send(32'hA0, 32'h0, 5'd10, 2'd0, 3'd0, 1'b0);
        send(32'hB0, 32'h0, 5'd11, 2'd0, 3'd0, 1'b0);
        send(32'hC0, 32'h0, 5'd12, 2'd0, 3'd0, 1'b0);
        repeat (3) idle(1'b1);

        // Flush with both entries full and a same-cycle offer.
        send(32'hD0, 32'h0, 5'd13, 2'd0, 3'd0, 1'b0);
        send(32'hE0, 32'h0, 5'd14, 2'd0, 3'd0, 1'b0);
        step(1'b1, 32'hF0, 32'h0, 32'h0, 5'd15, 2'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        idle(1'b1);

        // Load extension against fixed expected words.
        step(1'b1, 32'h1001, 32'h80FF7F01, 32'h0, 5'd6, 2'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000007F);
        step(1'b1, 32'h1003, 32'h80FF7F01, 32'h0, 5'd7, 2'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFF80);
        step(1'b1, 32'h1002, 32'h80FF7F01, 32'h0, 5'd8, 2'd1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h000080FF);
        step(1'b1, 32'h1000, 32'h80FF7F01, 32'h0, 5'd9, 2'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00007F01);
        idle(1'b1);

        // rd=0 link write: data visible, no write, no forward.
        step(1'b1, 32'hDEAD, 32'h0, 32'h104, 5'd0, 2'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h104);
        chk("x0_wb_data", 64'(wb_data), 64'h104);
        chk("x0_wb_we", 64'(wb_we), 64'd0);
        chk("x0_fwd_valid", 64'(fwd_valid), 64'd0);
        idle(1'b1);

        // Reset while an entry is presented.
        send(32'h55, 32'h0, 5'd3, 2'd0, 3'd0, 1'b0);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_wb_we", 64'(wb_we), 64'd0);
        chk("midrst_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_out_valid", 64'(out_valid), 64'd0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = $urandom;
            step($urandom_range(0, 99) < 60, a, $urandom, a + 32'd4, 5'($urandom_range(0, 31)),
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 4, 1'b0, 32'd0);
        end

        for (int n = 0; n < 10; n++) begin
            if (q.size() == 0) break;
            idle(1'b1);
        end
        chk("drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
